// File: rtl/ft833_bus_pkg.sv
// Shared types and helpers for the FT833 system-bus bridge.
package ft833_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADRW,
    RBCHK,
    BUS,
    DONE
  } bridge_state_t;

  // Read data returned to the CPU when a bus cycle errors or times out.
  localparam logic [7:0] BERR_DATA = 8'hFF;

  function automatic logic [3:0] lane_sel(input logic [1:0] badr);
    return 4'b0001 << badr;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] badr);
    return word[{badr, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ft833_rbuf.sv
// One-word read buffer: tag/valid lookup, fill, write-through byte update, invalidate.
module ft833_rbuf
  import ft833_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] tag,
  output logic        hit,
  output logic [31:0] word,
  input  logic        fill,
  input  logic [31:0] fill_data,
  input  logic        upd,
  input  logic [1:0]  upd_lane,
  input  logic [7:0]  upd_byte,
  input  logic        inval
);

  logic        vld;
  logic [23:0] tag_q;
  logic [31:0] data_q;

  assign hit  = vld && (tag_q == tag);
  assign word = data_q;

  always_ff @(posedge clk) begin
    if (rst)        vld <= 1'b0;
    else if (inval) vld <= 1'b0;
    else if (fill)  vld <= 1'b1;
  end

  // Updates only land on the buffered word, so writes elsewhere leave it untouched.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q  <= tag;
      data_q <= fill_data;
    end else if (upd && hit) begin
      data_q[{upd_lane, 3'b000} +: 8] <= upd_byte;
    end
  end

endmodule

// File: rtl/ft833_bus_bridge.sv
// FT833 MMU-to-system-bus bridge: stalls the CPU through a 32-bit req/ack bus cycle,
// with a one-word read buffer and bus error / timeout reporting.
module ft833_bus_bridge
  import ft833_bus_pkg::*;
#(
  parameter int MMU_LAT   = 2,
  parameter int TO_CYCLES = 255,
  parameter bit RBUF_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [25:0] cpu_adr,
  input  logic [7:0]  cpu_dat_i,
  output logic [7:0]  cpu_dat_o,
  output logic        cpu_rdy,
  output logic        cpu_berr,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [25:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i
);

  bridge_state_t state, state_nx;

  logic [7:0]  lat_cnt;
  logic [9:0]  to_cnt;
  logic        rw;
  logic [7:0]  wdat;
  logic [25:0] adr;
  logic [7:0]  rdat;
  logic        berr;

  logic        hit;
  logic [31:0] buf_word;
  logic        timeout;
  logic        bus_fail;
  logic        bus_ok;

  // Timeout fires in the cycle the counter would reach zero, giving exactly TO_CYCLES bus clocks.
  assign timeout  = (to_cnt <= 10'd1);
  assign bus_fail = (state == BUS) && (err_i || timeout);
  assign bus_ok   = (state == BUS) && ack_i && !bus_fail;

  always_comb begin
    state_nx = state;
    cpu_rdy  = 1'b0;
    cyc_o    = 1'b0;
    stb_o    = 1'b0;
    we_o     = 1'b0;
    sel_o    = '0;
    adr_o    = '0;
    dat_o    = '0;
    case (state)
      IDLE: begin
        cpu_rdy = 1'b1;
        if (cpu_req) state_nx = ADRW;
      end
      ADRW: begin
        if (lat_cnt == '0) state_nx = (rw && RBUF_EN) ? RBCHK : BUS;
      end
      RBCHK: begin
        state_nx = hit ? DONE : BUS;
      end
      BUS: begin
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = ~rw;
        sel_o = lane_sel(adr[1:0]);
        adr_o = {adr[25:2], 2'b00};
        dat_o = {4{wdat}};
        if (bus_fail || ack_i) state_nx = DONE;
      end
      DONE: begin
        cpu_rdy  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      to_cnt  <= '0;
      berr    <= 1'b0;
      rdat    <= '0;
    end else begin
      state <= state_nx;
      berr  <= bus_fail;
      if (state == IDLE && cpu_req) lat_cnt <= 8'(MMU_LAT - 1);
      else if (state == ADRW && lat_cnt != '0) lat_cnt <= lat_cnt - 8'd1;
      if (state != BUS && state_nx == BUS) to_cnt <= 10'(TO_CYCLES);
      else if (state == BUS && to_cnt != '0) to_cnt <= to_cnt - 10'd1;
      if (state == RBCHK && hit)  rdat <= lane_byte(buf_word, adr[1:0]);
      else if (bus_fail)          rdat <= BERR_DATA;
      else if (bus_ok && rw)      rdat <= lane_byte(dat_i, adr[1:0]);
    end
  end

  // Cycle attributes are captured once; the CPU holds still while stalled.
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req) begin
      rw   <= cpu_rw;
      wdat <= cpu_dat_i;
    end
    if (state == ADRW && lat_cnt == '0) adr <= cpu_adr;
  end

  generate
    if (RBUF_EN) begin : g_rbuf
      ft833_rbuf u_rbuf (
        .clk       (clk),
        .rst       (rst),
        .tag       (adr[25:2]),
        .hit       (hit),
        .word      (buf_word),
        .fill      (bus_ok && rw),
        .fill_data (dat_i),
        .upd       (bus_ok && !rw),
        .upd_lane  (adr[1:0]),
        .upd_byte  (wdat),
        .inval     (bus_fail)
      );
    end else begin : g_norbuf
      assign hit      = 1'b0;
      assign buf_word = '0;
    end
  endgenerate

  assign cpu_dat_o = rdat;
  assign cpu_berr  = berr;

endmodule

// File: doc/ft833_bus_bridge.md
Name: ft833_bus_bridge

Overview:
- Downstream of the FT833 MMU.
- Consumes the 26-bit translated physical address plus the CPU cycle strobes, and runs a 32-bit request/acknowledge system-bus cycle.
- Holds the CPU via rdy until the bus cycle finishes.
- Keeps a one-word read buffer so sequential byte reads within a 32-bit word complete without a bus cycle.
- Reports bus errors and timeouts back to the CPU.

Parameters:
- MMU_LAT, 2: clk cycles from cpu_req until cpu_adr is valid (MMU table read plus output register).
- TO_CYCLES, 255: clk cycles to wait for ack_i/err_i before declaring a timeout; range 1..1023.
- RBUF_EN, 1: enables the one-word read buffer; 0 forces every read onto the bus.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cpu_req  in  1  one-clk pulse: CPU has started a valid (vda) data cycle
- cpu_rw  in  1  1 = read, 0 = write; sampled with cpu_req
- cpu_adr  in  26  physical address from the MMU; valid MMU_LAT clks after cpu_req
- cpu_dat_i  in  8  CPU write data; sampled with cpu_req
- cpu_dat_o  out  8  read data to the CPU; valid while cpu_rdy=1 after a read completes
- cpu_rdy  out  1  0 = stall the CPU
- cpu_berr  out  1  one-clk pulse: bus error or timeout on the current cycle
- cyc_o  out  1  bus cycle active
- stb_o  out  1  bus strobe
- we_o  out  1  bus write
- sel_o  out  4  byte lane select
- adr_o  out  26  bus byte address; adr_o[1:0] = 0
- dat_o  out  32  bus write data
- dat_i  in  32  bus read data
- ack_i  in  1  bus acknowledge
- err_i  in  1  bus error

Behaviour:
- Reset: rst is synchronous, active-high; clock clk.
  - Outputs after reset: cpu_rdy=1; cpu_berr, cyc_o, stb_o, we_o = 0; sel_o, adr_o, dat_o, cpu_dat_o = 0.
  - Read buffer is invalidated; FSM goes to IDLE.
  - rst asserted mid-cycle drops cyc_o/stb_o on the next edge; no ack is awaited.
- States: IDLE, ADRW, RBCHK, BUS, DONE.
- IDLE:
  - On cpu_req: latch cpu_rw and cpu_dat_i, drive cpu_rdy=0, load the latency counter with MMU_LAT-1, go to ADRW.
  - cpu_req while not in IDLE is ignored; the CPU is stalled, so this is a protocol violation.
- ADRW:
  - Counts down; at 0, latches cpu_adr.
  - Read with RBUF_EN=1 goes to RBCHK; all other cycles go to BUS.
- RBCHK, one clk:
  - Hit condition: buffer valid and tag == adr[25:2].
  - Hit: cpu_dat_o = buffered byte selected by adr[1:0], go to DONE.
  - Miss: go to BUS.
- BUS:
  - cyc_o = stb_o = 1; we_o = ~rw; adr_o = {adr[25:2],2'b00}; sel_o = 4'b0001 << adr[1:0].
  - dat_o = write byte replicated on all four lanes.
  - The timeout counter loads TO_CYCLES on entry.
  - ack_i:
    - Read: cpu_dat_o = dat_i byte adr[1:0]; buffer is loaded with dat_i, tag set, valid=1.
    - Write hitting the buffer tag: the buffered byte is updated (write-through).
    - Deassert cyc_o/stb_o, go to DONE.
  - err_i, or counter reaches 0: pulse cpu_berr, invalidate the buffer, cpu_dat_o = 8'hFF, go to DONE.
  - ack_i and err_i in the same clk: err wins.
- DONE: cpu_rdy=1 for this clk, return to IDLE. Bridge latency is therefore:
  - Buffer hit: MMU_LAT+2 clks from cpu_req to cpu_rdy.
  - Bus cycle: MMU_LAT+2+N clks, where N = ack wait.
- Timeout counter is 10 bits and does not wrap; it stops at 0.
- Any write to a word whose tag matches keeps the buffer coherent; writes to other words leave the buffer untouched.

Decomposition:
- Package ft833_bus_pkg:
  - bridge_state_t enum (IDLE, ADRW, RBCHK, BUS, DONE).
  - Constant BERR_DATA = 8'hFF.
  - Lane-select function: byte address to sel.
- Sub-module ft833_rbuf: one-word read buffer with tag/valid, lookup, fill, byte-update and invalidate ports. Used only when RBUF_EN=1.

Test Plan:
- Read miss:
  - Stimulus: cpu_req, rw=1, cpu_adr=26'h0012345; ack_i after 3 clks with dat_i=32'hDDCCBBAA.
  - Required: adr_o=26'h0012344, sel_o=4'b0010; cpu_dat_o=8'hBB; cpu_rdy returns at MMU_LAT+5.
- Read hit:
  - Stimulus: immediately after the miss, read 26'h0012347.
  - Required: no cyc_o; cpu_dat_o=8'hDD; cpu_rdy at MMU_LAT+2.
- Write-through coherency:
  - Stimulus: write 8'h5A to 26'h0012346, then read 26'h0012346.
  - Required: write shows sel_o=4'b0100, dat_o=32'h5A5A5A5A; the read hits and returns 8'h5A with no bus cycle.
- Timeout:
  - Stimulus: TO_CYCLES=4, read with no ack.
  - Required: cyc_o held for exactly 4 clks; cpu_berr pulses for 1 clk; cpu_dat_o=8'hFF; next read of the same word misses.
- Simultaneous ack_i and err_i:
  - Required: cpu_berr=1; buffer not filled.
- Reset mid-BUS:
  - Required: cyc_o=0 and cpu_rdy=1 on the next clk; a subsequent cycle completes normally.
